// File: rtl/fetch_unit_if.sv
// Fetch unit bus: PC register control, instruction-memory read port and decoder handoff.
// master is the fetch unit's view; slave is the surrounding PC/memory/decoder view.
interface fetch_unit_if #(
  parameter int unsigned DATA_LEN = 16,
  parameter int unsigned INST_LEN = 16
);
  logic [DATA_LEN-1:0] pc_in;
  logic                pc_inc;
  logic                pc_we;
  logic [DATA_LEN-1:0] pc_load_val;
  logic                imem_req;
  logic [DATA_LEN-1:0] imem_addr;
  logic                imem_ack;
  logic [INST_LEN-1:0] imem_rdata;
  logic [INST_LEN-1:0] inst_out;
  logic [DATA_LEN-1:0] inst_pc;
  logic                inst_valid;
  logic                inst_ready;
  logic                jump_req;
  logic [DATA_LEN-1:0] jump_target;
  logic                halt;
  logic [1:0]          fetch_state;

  modport master (
    input  pc_in, imem_ack, imem_rdata, inst_ready, jump_req, jump_target, halt,
    output pc_inc, pc_we, pc_load_val, imem_req, imem_addr, inst_out, inst_pc, inst_valid,
           fetch_state
  );

  modport slave (
    output pc_in, imem_ack, imem_rdata, inst_ready, jump_req, jump_target, halt,
    input  pc_inc, pc_we, pc_load_val, imem_req, imem_addr, inst_out, inst_pc, inst_valid,
           fetch_state
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: reads PC, fetches over req/ack, hands the word to the decoder
// over valid/ready, and steps or redirects the PC register.
module fetch_unit #(
  parameter int unsigned DATA_LEN = 16,
  parameter int unsigned INST_LEN = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StReq      = 2'd1,
    StHold     = 2'd2,
    StRedirect = 2'd3
  } state_e;

  state_e              state_q;
  logic                imem_req_q;
  logic [DATA_LEN-1:0] imem_addr_q;
  logic [INST_LEN-1:0] inst_out_q;
  logic [DATA_LEN-1:0] inst_pc_q;
  logic                hold_valid_q;
  logic                pc_inc_q;
  logic                pc_we_q;
  logic [DATA_LEN-1:0] pc_load_val_q;
  logic                jump_pend_q;
  logic [DATA_LEN-1:0] jump_tgt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      inst_out_q    <= '0;
      inst_pc_q     <= '0;
      hold_valid_q  <= 1'b0;
      pc_inc_q      <= 1'b0;
      pc_we_q       <= 1'b0;
      pc_load_val_q <= '0;
      jump_pend_q   <= 1'b0;
      jump_tgt_q    <= '0;
    end else begin
      // Strobes default low; each is raised only on entry to the state that owns it.
      pc_inc_q <= 1'b0;
      pc_we_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.jump_req) begin
            pc_load_val_q <= bus.jump_target;
            pc_we_q       <= 1'b1;
            state_q       <= StRedirect;
          end else if (!bus.halt) begin
            imem_addr_q <= bus.pc_in;
            imem_req_q  <= 1'b1;
            state_q     <= StReq;
          end
        end

        StReq: begin
          // The in-flight read is never aborted; a redirect waits for the ack.
          if (bus.jump_req) begin
            jump_pend_q <= 1'b1;
            jump_tgt_q  <= bus.jump_target;
          end
          if (bus.imem_ack) begin
            imem_req_q <= 1'b0;
            if (jump_pend_q || bus.jump_req) begin
              pc_load_val_q <= bus.jump_req ? bus.jump_target : jump_tgt_q;
              pc_we_q       <= 1'b1;
              state_q       <= StRedirect;
            end else begin
              inst_out_q   <= bus.imem_rdata;
              inst_pc_q    <= imem_addr_q;
              hold_valid_q <= 1'b1;
              pc_inc_q     <= 1'b1;
              state_q      <= StHold;
            end
          end
        end

        StHold: begin
          if (bus.jump_req) begin
            hold_valid_q  <= 1'b0;
            pc_load_val_q <= bus.jump_target;
            pc_we_q       <= 1'b1;
            state_q       <= StRedirect;
          end else if (hold_valid_q && bus.inst_ready) begin
            hold_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end

        StRedirect: begin
          jump_pend_q <= 1'b0;
          if (bus.jump_req) begin
            pc_load_val_q <= bus.jump_target;
            pc_we_q       <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.inst_out    = inst_out_q;
  assign bus.inst_pc     = inst_pc_q;
  // A same-cycle redirect must block the decoder handshake.
  assign bus.inst_valid  = hold_valid_q & ~bus.jump_req;
  assign bus.pc_inc      = pc_inc_q;
  assign bus.pc_we       = pc_we_q;
  assign bus.pc_load_val = pc_load_val_q;
  assign bus.fetch_state = state_q;

endmodule
